// File: rtl/motion_profile_calc.sv
// Single-axis stepper motion profile calculator: classifies a move request, then runs a
// shared restoring divider and shift-add multiplier to derive accel/cruise timing.
module motion_profile_calc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         const_speed,
  input  logic [W-1:0] steps,
  input  logic [W-1:0] max_acc_steps,
  input  logic [W-1:0] start_period,
  input  logic [W-1:0] min_period,
  input  logic [W-1:0] const_period,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] accel_steps,
  output logic [W-1:0] first_period,
  output logic [W-1:0] cruise_period,
  output logic [W-1:0] per_step
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLASSIFY, S_DIV, S_MUL, S_FIX, S_DONE
  } state_t;

  state_t          r_state;
  logic            r_busy, r_done, r_err;
  logic [W-1:0]    r_accel, r_first, r_cruise, r_per;
  logic [W-1:0]    r_steps, r_max, r_sp, r_mp, r_cp;
  logic            r_cs, r_trap;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_rem, r_quo;
  logic [2*W-1:0]  r_mcand, r_prod;
  logic [W-1:0]    r_mplier;
  logic [W-1:0]    r_w_accel, r_w_first, r_w_cruise, r_w_per;

  // Divider step: the dividend shifts out of r_quo's top while quotient bits enter below.
  logic [W:0]      w_trial, w_diff;
  logic            w_ge;
  logic [W-1:0]    w_rem_next, w_quo_next;
  logic [2*W-1:0]  w_prod_next;
  logic [W-1:0]    w_span, w_half, w_tri_accel, w_cruise_tri, w_p_low;
  logic            w_trap, w_err_cond;

  assign w_trial     = {r_rem, r_quo[W-1]};
  assign w_diff      = w_trial - {1'b0, r_max};
  assign w_ge        = (w_trial >= {1'b0, r_max});
  assign w_rem_next  = w_ge ? w_diff[W-1:0] : w_trial[W-1:0];
  assign w_quo_next  = {r_quo[W-2:0], w_ge};

  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_p_low     = w_prod_next[W-1:0];

  assign w_span      = r_sp - r_mp;
  assign w_half      = r_steps >> 1;
  assign w_tri_accel = (w_half == '0) ? {{(W-1){1'b0}}, 1'b1} : w_half;
  assign w_cruise_tri = (w_prod_next > {{W{1'b0}}, w_span}) ? r_mp : (r_sp - w_p_low);

  // Widened compare so 2*max_acc_steps+2 cannot wrap.
  assign w_trap     = ({2'b00, r_steps} >= (({2'b00, r_max}) << 1) + (W+2)'(2));
  assign w_err_cond = (r_max == '0) || (r_sp < r_mp);

  // NOTE: sequential state uses non-blocking assignments only; the synchronous reset
  // clears every register, including datapath, so an aborted move leaves no residue.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_accel    <= '0;
      r_first    <= '0;
      r_cruise   <= '0;
      r_per      <= '0;
      r_steps    <= '0;
      r_max      <= '0;
      r_sp       <= '0;
      r_mp       <= '0;
      r_cp       <= '0;
      r_cs       <= 1'b0;
      r_trap     <= 1'b0;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_mcand    <= '0;
      r_prod     <= '0;
      r_mplier   <= '0;
      r_w_accel  <= '0;
      r_w_first  <= '0;
      r_w_cruise <= '0;
      r_w_per    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_steps <= steps;
            r_max   <= max_acc_steps;
            r_sp    <= start_period;
            r_mp    <= min_period;
            r_cp    <= const_period;
            r_cs    <= const_speed;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_CLASSIFY;
          end
        end

        S_CLASSIFY: begin
          if (r_steps == '0) begin
            r_accel  <= '0;
            r_first  <= '0;
            r_cruise <= '0;
            r_per    <= '0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else if (r_cs) begin
            r_accel  <= '0;
            r_first  <= r_cp;
            r_cruise <= r_cp;
            r_per    <= '0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else if (w_err_cond) begin
            r_accel  <= '0;
            r_first  <= r_sp;
            r_cruise <= r_sp;
            r_per    <= '0;
            r_err    <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_rem   <= '0;
            r_quo   <= w_span;
            r_cnt   <= '0;
            r_trap  <= w_trap;
            r_state <= S_DIV;
          end
        end

        S_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W-1)) begin
            r_w_first <= r_sp;
            r_w_per   <= w_quo_next;
            if (r_trap) begin
              r_w_accel  <= r_max;
              r_w_cruise <= r_mp;
              r_state    <= S_FIX;
            end else begin
              r_w_accel <= w_tri_accel;
              r_mcand   <= {{W{1'b0}}, w_quo_next};
              r_mplier  <= w_tri_accel;
              r_prod    <= '0;
              r_cnt     <= '0;
              r_state   <= S_MUL;
            end
          end
        end

        S_MUL: begin
          r_prod   <= w_prod_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CW'(W-1)) begin
            r_w_cruise <= w_cruise_tri;
            r_state    <= S_FIX;
          end
        end

        S_FIX: begin
          r_accel  <= r_w_accel;
          r_first  <= r_w_first;
          r_cruise <= r_w_cruise;
          // A zero decrement would never reach cruise; force at least one tick per step.
          r_per    <= ((r_w_per == '0) && (r_w_first != r_w_cruise)) ?
                      {{(W-1){1'b0}}, 1'b1} : r_w_per;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign accel_steps   = r_accel;
  assign first_period  = r_first;
  assign cruise_period = r_cruise;
  assign per_step      = r_per;

endmodule

// File: tb/tb_motion_profile_calc.sv
// Randomized and directed bench for motion_profile_calc, checked against an arithmetic
// model of the profile rules, including done latency and the busy/done handshake.
module tb_motion_profile_calc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         const_speed = 1'b0;
  logic [W-1:0] steps = '0, max_acc_steps = '0, start_period = '0;
  logic [W-1:0] min_period = '0, const_period = '0;
  logic         busy, done, err;
  logic [W-1:0] accel_steps, first_period, cruise_period, per_step;

  int checks = 0;
  int failures = 0;

  motion_profile_calc #(.W(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .const_speed(const_speed),
    .steps(steps), .max_acc_steps(max_acc_steps), .start_period(start_period),
    .min_period(min_period), .const_period(const_period),
    .busy(busy), .done(done), .err(err),
    .accel_steps(accel_steps), .first_period(first_period),
    .cruise_period(cruise_period), .per_step(per_step)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned accel, first, cruise, per;
    bit              err;
    int              lat;
  } exp_t;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input bit cs, input longint unsigned st, ma, sp, mp, cp);
    exp_t e;
    longint unsigned d, a, p;
    e = '{accel: 0, first: 0, cruise: 0, per: 0, err: 0, lat: 2};
    if (st == 0) return e;
    if (cs) begin
      e.first = cp; e.cruise = cp;
      return e;
    end
    if (ma == 0 || sp < mp) begin
      e.first = sp; e.cruise = sp; e.err = 1;
      return e;
    end
    d = (sp - mp) / ma;
    e.first = sp;
    e.per   = d;
    if (st >= 2 * ma + 2) begin
      e.accel = ma; e.cruise = mp; e.lat = W + 3;
    end else begin
      a = (st / 2 == 0) ? 1 : st / 2;
      p = d * a;
      e.accel  = a;
      e.cruise = (p > sp - mp) ? mp : sp - p;
      e.lat    = 2 * W + 3;
    end
    if (e.per == 0 && e.first != e.cruise) e.per = 1;
    return e;
  endfunction

  task automatic run_move(input string tag, input bit cs, input logic [W-1:0] st, ma, sp, mp,
                          cp, input bit probe, input bit dstart);
    exp_t e;
    int   cyc;
    e = model(cs, st, ma, sp, mp, cp);
    @(negedge clk);
    const_speed = cs; steps = st; max_acc_steps = ma;
    start_period = sp; min_period = mp; const_period = cp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_c1"}, busy, 1);
    check({tag, "_err_clr"}, err, 0);
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      if (probe) begin
        start = 1'b1;
        steps = $urandom; max_acc_steps = $urandom; start_period = $urandom;
        min_period = $urandom; const_speed = $urandom_range(0, 1);
      end
      @(negedge clk);
      cyc++;
    end
    start = dstart;
    check({tag, "_lat"}, cyc, e.lat);
    check({tag, "_busy_done"}, busy, 1);
    check({tag, "_accel"}, accel_steps, e.accel);
    check({tag, "_first"}, first_period, e.first);
    check({tag, "_cruise"}, cruise_period, e.cruise);
    check({tag, "_per"}, per_step, e.per);
    check({tag, "_err"}, err, e.err);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_hold"}, cruise_period, e.cruise);
    // A start held in the DONE cycle must not have launched a new move.
    @(negedge clk);
    check({tag, "_stay_idle"}, busy, 0);
  endtask

  initial begin
    bit              cs;
    logic [W-1:0]    st, ma, sp, mp, cp;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_accel", accel_steps, 0);
    check("rst_first", first_period, 0);
    check("rst_cruise", cruise_period, 0);
    check("rst_per", per_step, 0);
    reset_n = 1'b1;

    run_move("zero",  0, 0,    100, 2000, 500, 7,   0, 0);
    run_move("const", 1, 100,  100, 2000, 500, 500, 0, 1);
    run_move("trap",  0, 1000, 100, 2000, 500, 0,   0, 0);
    run_move("tri",   0, 50,   100, 2000, 500, 0,   0, 1);
    run_move("dzero", 0, 1000, 100, 600,  550, 0,   0, 0);
    run_move("errma", 0, 1000, 0,   600,  550, 0,   0, 0);
    run_move("errsp", 0, 1000, 100, 400,  550, 0,   0, 0);
    run_move("one",   0, 1,    100, 2000, 500, 0,   0, 0);
    run_move("sat",   0, 20,   11,  1000, 1,   0,   0, 0);
    run_move("bigma", 0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 3, 0, 0, 0);

    // Reset in the middle of a trapezoid computation aborts it.
    @(negedge clk);
    const_speed = 0; steps = 1000; max_acc_steps = 100; start_period = 2000; min_period = 500;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    check("abort_first", first_period, 0);
    check("abort_cruise", cruise_period, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    run_move("retry", 0, 1000, 100, 2000, 500, 0, 1, 0);

    for (int i = 0; i < 25; i++) begin
      cs = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 5000));
      ma = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 1500));
      mp = W'($urandom_range(1, 3000));
      sp = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 3000)) : mp + W'($urandom_range(0, 100000));
      cp = $urandom;
      run_move($sformatf("rnd%0d", i), cs, st, ma, sp, mp, cp, $urandom_range(0, 1),
               $urandom_range(0, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
